// File: rtl/vsync_extractor.sv
// Recovers filtered HSYNC/VSYNC/DE from channel-0 TMDS control tokens and tracks frame line counts for lock.
// Latency: outputs update on the sample edge (pulse one cycle later); no backpressure, a valid_data drop resets the link.
module vsync_extractor #(
  parameter int SAMPLE_DIV = 5,
  parameter int DEBOUNCE   = 4
) (
  input  logic        bit_clk,
  input  logic        rst_n,
  input  logic [9:0]  tmds_word,
  input  logic        valid_data,
  output logic        hsync,
  output logic        vsync,
  output logic        vsync_pulse,
  output logic        de,
  output logic [10:0] lines_per_frame,
  output logic [7:0]  frame_count,
  output logic        locked
);

  localparam int              PW       = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PW-1:0]   PH_LAST  = PW'(SAMPLE_DIV - 1);
  localparam logic [2:0]      RUN_LAST = 3'(DEBOUNCE - 1);
  localparam logic [10:0]     LINE_MAX = 11'h7FF;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEARCH  = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;

  logic [PW-1:0] phase;
  logic [1:0]    state;
  logic [2:0]    run_h;
  logic [2:0]    run_v;
  logic          vsync_d;
  logic [10:0]   line_cnt;

  logic          sample;
  logic          is_ctrl;
  logic [1:0]    ctrl_bits;
  logic          ctrl_sample;
  logic          h_flip;
  logic          v_flip;
  logic          h_rise;
  logic          v_rise;
  logic          frame_match;

  assign sample = valid_data && (phase == PH_LAST);

  always_comb begin
    is_ctrl   = 1'b1;
    ctrl_bits = 2'b00;
    case (tmds_word)
      10'h354: ctrl_bits = 2'b00;
      10'h0AB: ctrl_bits = 2'b01;
      10'h154: ctrl_bits = 2'b10;
      10'h2AB: ctrl_bits = 2'b11;
      default: is_ctrl   = 1'b0;
    endcase
  end

  // A flip fires on the DEBOUNCE-th consecutive disagreeing control sample.
  assign ctrl_sample = sample && is_ctrl;
  assign h_flip      = ctrl_sample && (ctrl_bits[0] != hsync) && (run_h == RUN_LAST);
  assign v_flip      = ctrl_sample && (ctrl_bits[1] != vsync) && (run_v == RUN_LAST);
  assign h_rise      = h_flip && !hsync;
  assign v_rise      = v_flip && !vsync;
  assign frame_match = (line_cnt == lines_per_frame) && (lines_per_frame != 11'd0);
  assign locked      = (state == ST_LOCKED);

  always_ff @(posedge bit_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      de    <= 1'b0;
    end else if (!valid_data) begin
      phase <= '0;
      de    <= 1'b0;
    end else begin
      phase <= (phase == PH_LAST) ? '0 : phase + PW'(1);
      if (sample) de <= !is_ctrl;
    end
  end

  always_ff @(posedge bit_clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync <= 1'b0;
      vsync <= 1'b0;
      run_h <= 3'd0;
      run_v <= 3'd0;
    end else if (!valid_data) begin
      hsync <= 1'b0;
      vsync <= 1'b0;
      run_h <= 3'd0;
      run_v <= 3'd0;
    end else if (ctrl_sample) begin
      if (ctrl_bits[0] == hsync) begin
        run_h <= 3'd0;
      end else if (h_flip) begin
        hsync <= ~hsync;
        run_h <= 3'd0;
      end else begin
        run_h <= run_h + 3'd1;
      end
      if (ctrl_bits[1] == vsync) begin
        run_v <= 3'd0;
      end else if (v_flip) begin
        vsync <= ~vsync;
        run_v <= 3'd0;
      end else begin
        run_v <= run_v + 3'd1;
      end
    end
  end

  always_ff @(posedge bit_clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d     <= 1'b0;
      vsync_pulse <= 1'b0;
    end else if (!valid_data) begin
      vsync_d     <= 1'b0;
      vsync_pulse <= 1'b0;
    end else begin
      vsync_d     <= vsync;
      vsync_pulse <= vsync && !vsync_d;
    end
  end

  always_ff @(posedge bit_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      line_cnt        <= 11'd0;
      lines_per_frame <= 11'd0;
      frame_count     <= 8'd0;
    end else if (!valid_data) begin
      state    <= ST_IDLE;
      line_cnt <= 11'd0;
    end else begin
      // A coincident hsync rise belongs to the new frame.
      if (v_rise && (state != ST_IDLE)) begin
        line_cnt <= {10'd0, h_rise};
      end else if (h_rise && (line_cnt != LINE_MAX)) begin
        line_cnt <= line_cnt + 11'd1;
      end
      case (state)
        ST_IDLE: state <= ST_SEARCH;
        ST_SEARCH: begin
          if (v_rise) begin
            state       <= ST_MEASURE;
            frame_count <= 8'd0;
          end
        end
        ST_MEASURE, ST_LOCKED: begin
          if (v_rise) begin
            lines_per_frame <= line_cnt;
            frame_count     <= frame_count + 8'd1;
            state           <= frame_match ? ST_LOCKED : ST_MEASURE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
